dpram_lanes: RTL and testbench

Generalised true dual-port RAM with per-lane write enables. Lane width, lane count and address width are parameters. Adds an optional registered output stage, deterministic same-address collision resolution with a collision flag, and a post-reset clear sequencer that zeroes the array. Used as the common on-chip memory primitive for caches, register files and scratchpads across targets.

---
 rtl/dpram_lanes.sv | 172 +++++++++++++++++
 tb/tb_dpram_lanes.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_lanes.sv
// dpram_lanes: true dual-port RAM with per-lane write enables.
//
// Both ports can read and write every cycle. Each port has one write-enable
// lane per LANE_WIDTH bits. A clear sequencer zeroes the array after reset
// (unless CLEAR_ON_RESET=0), and user accesses are ignored until it is done.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ready                   high while user accesses are accepted
//   address_p, byteena_p,   per-port address, lane enables, write data and
//   wrdata_p, wren_p        write strobe (p = a, b)
//   rddata_p                read data, 1 cycle (OUT_REG=0) or 2 cycles
//                           (OUT_REG=1) after the address
//   collision               one-cycle pulse after a same-address access in
//                           which at least one port wrote a non-empty lane set
module dpram_lanes #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             ready,
  input  logic [ADDR_WIDTH-1:0]            address_a,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] byteena_a,
  input  logic [DATA_WIDTH-1:0]            wrdata_a,
  input  logic                             wren_a,
  output logic [DATA_WIDTH-1:0]            rddata_a,
  input  logic [ADDR_WIDTH-1:0]            address_b,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] byteena_b,
  input  logic [DATA_WIDTH-1:0]            wrdata_b,
  input  logic                             wren_b,
  output logic [DATA_WIDTH-1:0]            rddata_b,
  output logic                             collision
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
      $error("dpram_lanes: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
  endgenerate

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_a_p0_q, rd_a_p0_d;
  logic [DATA_WIDTH-1:0]   rd_b_p0_q, rd_b_p0_d;
  logic                    coll_q, coll_d;
  logic [LANES-1:0]        we_a, we_b;
  logic                    clr_en;

  assign ready = (state_q == READY);

  // Effective lane writes: only in READY, and a reset cycle drops them.
  always_comb begin
    we_a   = '0;
    we_b   = '0;
    clr_en = 1'b0;
    if (!reset) begin
      if (state_q == READY) begin
        if (wren_a) we_a = byteena_a;
        if (wren_b) we_b = byteena_b;
      end else if (CLEAR_ON_RESET != 0) begin
        clr_en = 1'b1;
      end
    end
  end

  // Clear sequencer: one word per cycle, READY after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Read stage p0: own-port written lanes are forwarded (write-through);
  // everything else, including lanes the other port writes now, comes from
  // the array contents before this edge.
  always_comb begin
    rd_a_p0_d = '0;
    rd_b_p0_d = '0;
    coll_d    = 1'b0;
    if (state_q == READY) begin
      for (int i = 0; i < LANES; i++) begin
        rd_a_p0_d[i*LANE_WIDTH +: LANE_WIDTH] = we_a[i] ?
          wrdata_a[i*LANE_WIDTH +: LANE_WIDTH] :
          mem_q[address_a][i*LANE_WIDTH +: LANE_WIDTH];
        rd_b_p0_d[i*LANE_WIDTH +: LANE_WIDTH] = we_b[i] ?
          wrdata_b[i*LANE_WIDTH +: LANE_WIDTH] :
          mem_q[address_b][i*LANE_WIDTH +: LANE_WIDTH];
      end
      coll_d = (address_a == address_b) && ((|we_a) || (|we_b));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      rd_a_p0_q <= '0;
      rd_b_p0_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_a_p0_q <= rd_a_p0_d;
      rd_b_p0_q <= rd_b_p0_d;
      coll_q    <= coll_d;
    end
  end

  // Array: B lanes are written first so that A wins lanes both ports enable
  // on the same address.
  always_ff @(posedge clock) begin
    if (clr_en) mem_q[cnt_q] <= '0;
    for (int i = 0; i < LANES; i++) begin
      if (we_b[i]) mem_q[address_b][i*LANE_WIDTH +: LANE_WIDTH] <= wrdata_b[i*LANE_WIDTH +: LANE_WIDTH];
    end
    for (int i = 0; i < LANES; i++) begin
      if (we_a[i]) mem_q[address_a][i*LANE_WIDTH +: LANE_WIDTH] <= wrdata_a[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign collision = coll_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_a_p1_q, rd_a_p1_d;
      logic [DATA_WIDTH-1:0] rd_b_p1_q, rd_b_p1_d;

      always_comb begin
        rd_a_p1_d = rd_a_p0_q;
        rd_b_p1_d = rd_b_p0_q;
      end

      // Stage p1: extra output register.
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_a_p1_q <= '0;
          rd_b_p1_q <= '0;
        end else begin
          rd_a_p1_q <= rd_a_p1_d;
          rd_b_p1_q <= rd_b_p1_d;
        end
      end

      assign rddata_a = rd_a_p1_q;
      assign rddata_b = rd_b_p1_q;
    end else begin : g_no_out_reg
      assign rddata_a = rd_a_p0_q;
      assign rddata_b = rd_b_p0_q;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_lanes.sv
// Bench for dpram_lanes: default instance checked every cycle against a
// word-array model, plus a second instance (OUT_REG=1, 9-bit lanes,
// CLEAR_ON_RESET=0) exercised with directed sequences.
module tb_dpram_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instance 1: defaults ----------------
  logic        reset;
  logic        ready;
  logic [6:0]  address_a, address_b;
  logic [3:0]  byteena_a, byteena_b;
  logic [31:0] wrdata_a, wrdata_b, rddata_a, rddata_b;
  logic        wren_a, wren_b, collision;

  dpram_lanes u_dut (
    .clock(clk), .reset(reset), .ready(ready),
    .address_a(address_a), .byteena_a(byteena_a), .wrdata_a(wrdata_a),
    .wren_a(wren_a), .rddata_a(rddata_a),
    .address_b(address_b), .byteena_b(byteena_b), .wrdata_b(wrdata_b),
    .wren_b(wren_b), .rddata_b(rddata_b), .collision(collision)
  );

  // ---------------- instance 2: OUT_REG=1, 36/9, no clear ----------------
  logic        c_reset, c_ready, c_wren_a, c_wren_b, c_collision;
  logic [3:0]  c_address_a, c_address_b, c_byteena_a, c_byteena_b;
  logic [35:0] c_wrdata_a, c_wrdata_b, c_rddata_a, c_rddata_b;

  dpram_lanes #(.DATA_WIDTH(36), .LANE_WIDTH(9), .ADDR_WIDTH(4),
                .OUT_REG(1), .CLEAR_ON_RESET(0)) u_dut2 (
    .clock(clk), .reset(c_reset), .ready(c_ready),
    .address_a(c_address_a), .byteena_a(c_byteena_a), .wrdata_a(c_wrdata_a),
    .wren_a(c_wren_a), .rddata_a(c_rddata_a),
    .address_b(c_address_b), .byteena_b(c_byteena_b), .wrdata_b(c_wrdata_b),
    .wren_b(c_wren_b), .rddata_b(c_rddata_b), .collision(c_collision)
  );

  // ---------------- behavioural model of instance 1 ----------------
  logic [31:0] mm [128];
  int          clr_left = 0;
  logic        e_ready, e_coll;
  logic [31:0] e_a, e_b;
  bit          en = 1'b0;

  function automatic logic [31:0] lane_mask(input logic en_w, input logic [3:0] be);
    logic [31:0] m = '0;
    if (en_w)
      for (int i = 0; i < 4; i++)
        if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  always @(posedge clk) begin
    logic [31:0] ma, mb;
    if (reset) begin
      clr_left = 128;
      e_ready = 1'b0; e_a = '0; e_b = '0; e_coll = 1'b0;
    end else if (clr_left > 0) begin
      mm[128 - clr_left] = '0;
      clr_left = clr_left - 1;
      e_ready = (clr_left == 0);
      e_a = '0; e_b = '0; e_coll = 1'b0;
    end else begin
      ma = lane_mask(wren_a, byteena_a);
      mb = lane_mask(wren_b, byteena_b);
      e_a = (wrdata_a & ma) | (mm[address_a] & ~ma);
      e_b = (wrdata_b & mb) | (mm[address_b] & ~mb);
      e_coll = (address_a == address_b) && (ma != 0 || mb != 0);
      mm[address_b] = (wrdata_b & mb) | (mm[address_b] & ~mb);
      mm[address_a] = (wrdata_a & ma) | (mm[address_a] & ~ma);
      e_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("ready", 64'(ready), 64'(e_ready));
      chk("rddata_a", 64'(rddata_a), 64'(e_a));
      chk("rddata_b", 64'(rddata_b), 64'(e_b));
      chk("collision", 64'(collision), 64'(e_coll));
    end
  end

  task automatic cyc(input logic rst,
                     input logic wa, input logic [3:0] bea, input logic [6:0] aa, input logic [31:0] da,
                     input logic wb, input logic [3:0] beb, input logic [6:0] ab, input logic [31:0] db);
    @(negedge clk);
    reset = rst;
    wren_a = wa; byteena_a = bea; address_a = aa; wrdata_a = da;
    wren_b = wb; byteena_b = beb; address_b = ab; wrdata_b = db;
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0);
  endtask

  task automatic ccyc(input logic rst, input logic wb, input logic [3:0] beb,
                      input logic [3:0] ab, input logic [35:0] db, input logic [3:0] aa);
    @(negedge clk);
    c_reset = rst;
    c_wren_b = wb; c_byteena_b = beb; c_address_b = ab; c_wrdata_b = db;
    c_address_a = aa;
  endtask

  task automatic wait_ready(input string nm, input int want);
    int n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wren_a = 0; byteena_a = 0; address_a = 0; wrdata_a = 0;
    wren_b = 0; byteena_b = 0; address_b = 0; wrdata_b = 0;
    c_reset = 1'b1; c_wren_a = 0; c_byteena_a = 0; c_address_a = 0; c_wrdata_a = 0;
    c_wren_b = 0; c_byteena_b = 0; c_address_b = 0; c_wrdata_b = 0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_rddata_a", 64'(rddata_a), 64'h0);
    chk("rst_collision", 64'(collision), 64'h0);

    // Release with writes pending: they must be ignored during the clear.
    cyc(0, 1, 4'hF, 7'd1, 32'hFFFFFFFF, 1, 4'hF, 7'd2, 32'hFFFFFFFF);
    repeat (39) @(negedge clk);
    // Reset mid-clear with a write presented.
    cyc(1, 1, 4'hF, 7'd7, 32'h12345678, 0, 4'h0, 7'd0, 32'h0);
    cyc(0, 1, 4'hF, 7'd7, 32'h12345678, 0, 4'h0, 7'd0, 32'h0);
    wait_ready("clear_len_restart", 128);
    idle();
    for (int i = 0; i < 128; i++)
      cyc(0, 0, 4'h0, 7'(i), 32'h0, 0, 4'h0, 7'(127 - i), 32'h0);
    idle();
    chk("sweep_last_a", 64'(rddata_a), 64'h0);

    // Partial-lane write and write-through.
    cyc(0, 1, 4'b0101, 7'd5, 32'hDEADBEEF, 0, 4'h0, 7'd6, 32'h0);
    cyc(0, 0, 4'h0, 7'd5, 32'h0, 0, 4'h0, 7'd6, 32'h0);
    chk("wt_addr5", 64'(rddata_a), 64'h00AD00EF);
    idle();
    chk("rd_addr5", 64'(rddata_a), 64'h00AD00EF);

    // Both ports write addr 9.
    cyc(0, 1, 4'hF, 7'd9, 32'h11111111, 1, 4'b1100, 7'd9, 32'h22222222);
    cyc(0, 0, 4'h0, 7'd9, 32'h0, 0, 4'h0, 7'd10, 32'h0);
    chk("coll_ww", 64'(collision), 64'h1);
    idle();
    chk("word_addr9", 64'(rddata_a), 64'h11111111);
    chk("coll_clear", 64'(collision), 64'h0);

    // Cross-port read of a word being written.
    cyc(0, 1, 4'hF, 7'd3, 32'hAAAAAAAA, 0, 4'h0, 7'd0, 32'h0);
    cyc(0, 1, 4'hF, 7'd3, 32'h55555555, 0, 4'h0, 7'd3, 32'h0);
    cyc(0, 0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd3, 32'h0);
    chk("xport_old", 64'(rddata_b), 64'hAAAAAAAA);
    chk("coll_rw", 64'(collision), 64'h1);
    idle();
    chk("xport_new", 64'(rddata_b), 64'h55555555);

    // Empty-lane write is a plain read: no collision.
    cyc(0, 1, 4'h0, 7'd4, 32'hFFFFFFFF, 0, 4'h0, 7'd4, 32'h0);
    idle();
    chk("coll_be0", 64'(collision), 64'h0);

    // Randomized traffic, with the occasional reset.
    for (int k = 0; k < 3000; k++) begin
      logic [6:0] aa, ab;
      aa = ($urandom % 2) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      ab = ($urandom % 2) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      cyc(($urandom % 700) == 0,
          1'($urandom), 4'($urandom), aa, $urandom,
          1'($urandom), 4'($urandom), ab, $urandom);
    end
    cyc(1, 0, 4'h0, 7'd0, 32'h0, 0, 4'h0, 7'd0, 32'h0);
    idle();
    wait_ready("clear_len", 128);
    idle();

    // Instance 2.
    chk("c_rst_ready", 64'(c_ready), 64'h0);
    chk("c_rst_rddata", 64'(c_rddata_a), 64'h0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    ccyc(0, 1, 4'hF, 4'd1, 36'h0, 4'd2);
    chk("c_ready_1cyc", 64'(c_ready), 64'h1);
    ccyc(0, 1, 4'hF, 4'd0, 36'h123456789, 4'd1);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    chk("c_lat_early", 64'(c_rddata_a), 64'h0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    chk("c_lat2", 64'(c_rddata_a), 64'h123456789);
    ccyc(1, 1, 4'hF, 4'd0, 36'hFFFFFFFFF, 4'd0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    chk("c_reset_ready", 64'(c_ready), 64'h0);
    chk("c_reset_rddata", 64'(c_rddata_a), 64'h0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    chk("c_ready_again", 64'(c_ready), 64'h1);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd0);
    chk("c_drop_rst_wr", 64'(c_rddata_a), 64'h123456789);
    ccyc(0, 1, 4'hF, 4'd2, 36'h0, 4'd0);
    ccyc(0, 1, 4'b0010, 4'd2, 36'hFFFFFFFFF, 4'd0);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd2);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd2);
    ccyc(0, 0, 4'h0, 4'd0, 36'h0, 4'd2);
    chk("c_lane9", 64'(c_rddata_a), 64'h00003FE00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
